// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage sequencer between EX/MEM and the ram_2 data-memory interface
module mem_access_ctrl #(
    parameter int READ_LAT = 1,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic          i_req_re,
    input  logic [3:0]    i_req_type,
    input  logic          i_req_sign,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdat,
    input  logic [4:0]    i_req_rd,
    input  logic          i_flush,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdat,
    output logic          o_ram_we,
    output logic          o_ram_re,
    output logic [3:0]    o_ram_type,
    output logic          o_ram_sign,
    output logic          o_ram_port,
    input  logic [DW-1:0] i_ram_data,
    input  logic          i_ram_misaligned,
    output logic          o_wb_valid,
    output logic [DW-1:0] o_wb_data,
    output logic [4:0]    o_wb_rd,
    output logic          o_exc_valid,
    output logic [AW-1:0] o_exc_addr,
    output logic          o_exc_store,
    output logic          o_busy
);

    localparam int CW = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdat;
    logic [3:0]    req_type;
    logic          req_sign;
    logic [4:0]    req_rd;
    logic          req_we;
    logic          req_re;
    logic          accept;

    // NOP requests (neither we nor re) are consumed without leaving IDLE
    assign accept = i_req_valid & o_req_ready & (i_req_we | i_req_re) & ~i_flush;

    assign o_req_ready = (state == S_IDLE);
    assign o_busy      = ~o_req_ready;
    assign o_ram_addr  = req_addr;
    assign o_ram_wdat  = req_wdat;
    assign o_ram_type  = req_type;
    assign o_ram_sign  = req_sign;
    assign o_ram_port  = 1'b0;
    assign o_ram_we    = (state == S_ACCESS) & req_we;
    assign o_ram_re    = ((state == S_ACCESS) | (state == S_RDWAIT)) & req_re;
    assign o_wb_valid  = (state == S_RESP) & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_addr    <= '0;
            req_wdat    <= '0;
            req_type    <= '0;
            req_sign    <= 1'b0;
            req_rd      <= '0;
            req_we      <= 1'b0;
            req_re      <= 1'b0;
            o_wb_data   <= '0;
            o_wb_rd     <= '0;
            o_exc_valid <= 1'b0;
            o_exc_addr  <= '0;
            o_exc_store <= 1'b0;
        end else begin
            o_exc_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_addr <= i_req_addr;
                        req_wdat <= i_req_wdat;
                        req_type <= i_req_type;
                        req_sign <= i_req_sign;
                        req_rd   <= i_req_rd;
                        req_we   <= i_req_we;
                        req_re   <= i_req_re & ~i_req_we;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // a flushed store still commits, since o_ram_we is already up this cycle
                    if (!i_flush && i_ram_misaligned) begin
                        o_exc_valid <= 1'b1;
                        o_exc_addr  <= req_addr;
                        o_exc_store <= req_we;
                        state       <= S_IDLE;
                    end else if (i_flush || req_we) begin
                        state <= S_IDLE;
                    end else begin
                        cnt   <= CW'(READ_LAT);
                        state <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (i_flush) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == CW'(1)) begin
                        cnt       <= '0;
                        o_wb_data <= i_ram_data;
                        o_wb_rd   <= req_rd;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural ram_2 model
module tb_mem_access_ctrl;

    localparam logic [3:0] T_B = 4'd1;
    localparam logic [3:0] T_H = 4'd2;
    localparam logic [3:0] T_W = 4'd4;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        int          cyc;
    } wb_exp_t;

    typedef struct {
        logic [31:0] a;
        logic        st;
        int          cyc;
    } exc_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;
    int   addr_err = 0;
    logic [31:0] cur_addr2 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 1 (READ_LAT=1) signals
    logic        req_valid1 = 0, req_we1 = 0, req_re1 = 0, req_sign1 = 0, flush1 = 0;
    logic [3:0]  req_type1 = '0;
    logic [31:0] req_addr1 = '0, req_wdat1 = '0;
    logic [4:0]  req_rd1 = '0;
    logic        o_req_ready1, o_ram_we1, o_ram_re1, o_ram_sign1, o_ram_port1;
    logic        o_wb_valid1, o_exc_valid1, o_exc_store1, o_busy1, mis1;
    logic [3:0]  o_ram_type1;
    logic [31:0] o_ram_addr1, o_ram_wdat1, o_wb_data1, o_exc_addr1, rdat1;
    logic [4:0]  o_wb_rd1;

    // DUT 2 (READ_LAT=2) signals
    logic        req_valid2 = 0, req_we2 = 0, req_re2 = 0, req_sign2 = 0, flush2 = 0;
    logic [3:0]  req_type2 = '0;
    logic [31:0] req_addr2 = '0, req_wdat2 = '0;
    logic [4:0]  req_rd2 = '0;
    logic        o_req_ready2, o_ram_we2, o_ram_re2, o_ram_sign2, o_ram_port2;
    logic        o_wb_valid2, o_exc_valid2, o_exc_store2, o_busy2, mis2;
    logic [3:0]  o_ram_type2;
    logic [31:0] o_ram_addr2, o_ram_wdat2, o_wb_data2, o_exc_addr2, rdat2a, rdat2b;
    logic [4:0]  o_wb_rd2;

    logic [31:0] mem [0:63];

    wb_exp_t  wbq1[$];
    wb_exp_t  wbq2[$];
    exc_exp_t excq1[$];

    mem_access_ctrl #(.READ_LAT(1), .AW(32), .DW(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid1), .o_req_ready(o_req_ready1),
        .i_req_we(req_we1), .i_req_re(req_re1), .i_req_type(req_type1), .i_req_sign(req_sign1),
        .i_req_addr(req_addr1), .i_req_wdat(req_wdat1), .i_req_rd(req_rd1), .i_flush(flush1),
        .o_ram_addr(o_ram_addr1), .o_ram_wdat(o_ram_wdat1), .o_ram_we(o_ram_we1), .o_ram_re(o_ram_re1),
        .o_ram_type(o_ram_type1), .o_ram_sign(o_ram_sign1), .o_ram_port(o_ram_port1),
        .i_ram_data(rdat1), .i_ram_misaligned(mis1), .o_wb_valid(o_wb_valid1), .o_wb_data(o_wb_data1),
        .o_wb_rd(o_wb_rd1), .o_exc_valid(o_exc_valid1), .o_exc_addr(o_exc_addr1),
        .o_exc_store(o_exc_store1), .o_busy(o_busy1)
    );

    mem_access_ctrl #(.READ_LAT(2), .AW(32), .DW(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid2), .o_req_ready(o_req_ready2),
        .i_req_we(req_we2), .i_req_re(req_re2), .i_req_type(req_type2), .i_req_sign(req_sign2),
        .i_req_addr(req_addr2), .i_req_wdat(req_wdat2), .i_req_rd(req_rd2), .i_flush(flush2),
        .o_ram_addr(o_ram_addr2), .o_ram_wdat(o_ram_wdat2), .o_ram_we(o_ram_we2), .o_ram_re(o_ram_re2),
        .o_ram_type(o_ram_type2), .o_ram_sign(o_ram_sign2), .o_ram_port(o_ram_port2),
        .i_ram_data(rdat2b), .i_ram_misaligned(mis2), .o_wb_valid(o_wb_valid2), .o_wb_data(o_wb_data2),
        .o_wb_rd(o_wb_rd2), .o_exc_valid(o_exc_valid2), .o_exc_addr(o_exc_addr2),
        .o_exc_store(o_exc_store2), .o_busy(o_busy2)
    );

    function automatic logic misal(input logic [1:0] a, input logic [3:0] t);
        return ((t == T_H) && a[0]) || ((t == T_W) && (a != 2'b00));
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [3:0] t, input logic s);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        if (t == T_B) return s ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
        if (t == T_H) return s ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
        return w;
    endfunction

    assign mis1 = misal(o_ram_addr1[1:0], o_ram_type1);
    assign mis2 = misal(o_ram_addr2[1:0], o_ram_type2);

    // ram_2 model: byte-lane writes gated by misalignment, registered read data
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[8]  <= 32'hCAFEF00D;
            mem[16] <= 32'h11111111;
            mem[17] <= 32'h22222222;
            mem[18] <= 32'h33333333;
            rdat1  <= '0;
            rdat2a <= '0;
            rdat2b <= '0;
        end else begin
            if (o_ram_we1 && !mis1) begin
                if (o_ram_type1 == T_B)
                    mem[o_ram_addr1[7:2]][{o_ram_addr1[1:0], 3'b000} +: 8] <= o_ram_wdat1[7:0];
                else if (o_ram_type1 == T_H)
                    mem[o_ram_addr1[7:2]][{o_ram_addr1[1], 4'b0000} +: 16] <= o_ram_wdat1[15:0];
                else
                    mem[o_ram_addr1[7:2]] <= o_ram_wdat1;
            end
            if (o_ram_re1)
                rdat1 <= extract(mem[o_ram_addr1[7:2]], o_ram_addr1[1:0], o_ram_type1, o_ram_sign1);
            if (o_ram_re2)
                rdat2a <= extract(mem[o_ram_addr2[7:2]], o_ram_addr2[1:0], o_ram_type2, o_ram_sign2);
            rdat2b <= rdat2a;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen/missing at cycle %0d", name, cyc);
    endtask

    // monitor: pops the scoreboard whenever a DUT presents a pulse
    always @(negedge clk) begin
        wb_exp_t  w;
        exc_exp_t e;
        if (o_ram_we1) we_cnt++;
        if (o_busy2 && (o_ram_addr2 !== cur_addr2)) addr_err++;
        if (o_wb_valid1) begin
            if (wbq1.size() == 0) fail_now("wb1_unexpected");
            else begin
                w = wbq1.pop_front();
                chk("wb1_data", 64'(o_wb_data1), 64'(w.d));
                chk("wb1_rd", 64'(o_wb_rd1), 64'(w.rd));
                chk("wb1_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
        if (o_exc_valid1) begin
            if (excq1.size() == 0) fail_now("exc1_unexpected");
            else begin
                e = excq1.pop_front();
                chk("exc1_addr", 64'(o_exc_addr1), 64'(e.a));
                chk("exc1_store", 64'(o_exc_store1), 64'(e.st));
                chk("exc1_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (o_wb_valid2) begin
            if (wbq2.size() == 0) fail_now("wb2_unexpected");
            else begin
                w = wbq2.pop_front();
                chk("wb2_data", 64'(o_wb_data2), 64'(w.d));
                chk("wb2_rd", 64'(o_wb_rd2), 64'(w.rd));
                chk("wb2_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
        if (o_exc_valid2) fail_now("exc2_unexpected");
    end

    task automatic issue1(input logic we, input logic re, input logic [3:0] t, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          output int acc);
        int  n;
        int  c;
        bit  done;
        logic rdy;
        n = 0; done = 0; acc = -1;
        @(negedge clk);
        req_valid1 = 1; req_we1 = we; req_re1 = re; req_type1 = t; req_sign1 = s;
        req_addr1 = a; req_wdat1 = wd; req_rd1 = rd;
        while (!done) begin
            if (n > 50) begin
                fail_now("accept1_timeout");
                done = 1;
            end else begin
                c = cyc; rdy = o_req_ready1;
                @(posedge clk);
                if (rdy) begin done = 1; acc = c + 1; end
                else begin n++; @(negedge clk); end
            end
        end
    endtask

    task automatic issue2(input logic [31:0] a, input logic [4:0] rd, output int acc, output int waited);
        int  c;
        bit  done;
        logic rdy;
        waited = 0; done = 0; acc = -1;
        @(negedge clk);
        req_valid2 = 1; req_we2 = 0; req_re2 = 1; req_type2 = T_W; req_sign2 = 0;
        req_addr2 = a; req_rd2 = rd;
        while (!done) begin
            if (waited > 50) begin
                fail_now("accept2_timeout");
                done = 1;
            end else begin
                c = cyc; rdy = o_req_ready2;
                @(posedge clk);
                if (rdy) begin done = 1; acc = c + 1; cur_addr2 = a; end
                else begin waited++; @(negedge clk); end
            end
        end
    endtask

    task automatic drop1();
        @(negedge clk);
        req_valid1 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load1(input logic [3:0] t, input logic s, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] exp_d);
        int acc;
        issue1(0, 1, t, s, a, 32'h0, rd, acc);
        wbq1.push_back('{d: exp_d, rd: rd, cyc: acc + 2});
        drop1();
        idle(4);
    endtask

    task automatic store1(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd);
        int acc;
        issue1(1, 0, t, 1'b0, a, wd, 5'd0, acc);
        drop1();
        idle(3);
    endtask

    initial begin
        int acc;
        int w;
        rst_n = 0;
        #1;
        chk("rst_ready", 64'(o_req_ready1), 64'd1);
        chk("rst_busy", 64'(o_busy1), 64'd0);
        chk("rst_ram_we", 64'(o_ram_we1), 64'd0);
        chk("rst_ram_addr", 64'(o_ram_addr1), 64'd0);
        chk("rst_wb_valid", 64'(o_wb_valid1), 64'd0);
        chk("rst_exc_valid", 64'(o_exc_valid1), 64'd0);
        chk("rst_ram_port", 64'(o_ram_port1), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        idle(2);

        // 1: fullword store then load
        we_cnt = 0;
        store1(T_W, 32'h10, 32'hDEADBEEF);
        chk("store_we_cycles", 64'(we_cnt), 64'd1);
        load1(T_W, 1'b0, 32'h10, 5'd5, 32'hDEADBEEF);

        // 2: byte store and signed/unsigned byte loads
        store1(T_B, 32'h13, 32'h00000080);
        load1(T_B, 1'b1, 32'h13, 5'd6, 32'hFFFFFF80);
        load1(T_B, 1'b0, 32'h13, 5'd7, 32'h00000080);
        load1(T_H, 1'b1, 32'h12, 5'd8, 32'hFFFF80AD);

        // 3: misaligned load and store
        issue1(0, 1, T_H, 1'b0, 32'h21, 32'h0, 5'd9, acc);
        excq1.push_back('{a: 32'h21, st: 1'b0, cyc: acc + 1});
        drop1();
        idle(4);
        issue1(1, 0, T_W, 1'b0, 32'h22, 32'h12345678, 5'd0, acc);
        excq1.push_back('{a: 32'h22, st: 1'b1, cyc: acc + 1});
        drop1();
        idle(4);
        chk("exc_addr_hold", 64'(o_exc_addr1), 64'h22);
        load1(T_W, 1'b0, 32'h20, 5'd10, 32'hCAFEF00D);

        // 4: READ_LAT=2 back-to-back loads with valid held
        issue2(32'h40, 5'd1, acc, w);
        wbq2.push_back('{d: 32'h11111111, rd: 5'd1, cyc: acc + 3});
        issue2(32'h44, 5'd2, acc, w);
        chk("busy_cycles_ld2", 64'(w), 64'd4);
        wbq2.push_back('{d: 32'h22222222, rd: 5'd2, cyc: acc + 3});
        issue2(32'h48, 5'd3, acc, w);
        chk("busy_cycles_ld3", 64'(w), 64'd4);
        wbq2.push_back('{d: 32'h33333333, rd: 5'd3, cyc: acc + 3});
        @(negedge clk);
        req_valid2 = 0;
        idle(6);
        chk("addr2_stable_errs", 64'(addr_err), 64'd0);

        // 5: flush in RDWAIT of a load, and in ACCESS of a store
        issue1(0, 1, T_W, 1'b0, 32'h10, 32'h0, 5'd11, acc);
        @(negedge clk);
        req_valid1 = 0;
        @(negedge clk);
        flush1 = 1;
        @(negedge clk);
        flush1 = 0;
        chk("flush_load_idle", 64'(o_req_ready1), 64'd1);
        idle(3);
        issue1(1, 0, T_W, 1'b0, 32'h30, 32'hA5A5A5A5, 5'd0, acc);
        @(negedge clk);
        req_valid1 = 0;
        flush1 = 1;
        @(negedge clk);
        flush1 = 0;
        chk("flush_store_idle", 64'(o_req_ready1), 64'd1);
        idle(2);
        load1(T_W, 1'b0, 32'h30, 5'd12, 32'hA5A5A5A5);

        // 6: reset pulse during RDWAIT
        issue1(0, 1, T_W, 1'b0, 32'h40, 32'h0, 5'd13, acc);
        @(negedge clk);
        req_valid1 = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_ram_re", 64'(o_ram_re1), 64'd0);
        chk("midrst_ram_addr", 64'(o_ram_addr1), 64'd0);
        chk("midrst_busy", 64'(o_busy1), 64'd0);
        chk("midrst_wb_data", 64'(o_wb_data1), 64'd0);
        chk("midrst_wb_rd", 64'(o_wb_rd1), 64'd0);
        idle(2);
        rst_n = 1;
        idle(4);
        load1(T_W, 1'b0, 32'h44, 5'd14, 32'h22222222);

        idle(8);
        chk("wbq1_drained", 64'(wbq1.size()), 64'd0);
        chk("wbq2_drained", 64'(wbq2.size()), 64'd0);
        chk("excq1_drained", 64'(excq1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
